// File: rtl/alu_exec_unit_pkg.sv
// Shared ALU function codes and execute-unit FSM encodings.
// Also imported by the ALU control decoder so both sides agree on the codes.
package alu_exec_unit_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/alu_exec_unit_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier, one partial product per cycle.
// done pulses on the final step; product is valid only while done is high.
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mplr_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg;
    logic [WIDTH-1:0] acc_next;

    assign acc_next = acc_reg + (mplr_reg[0] ? mcand_reg : '0);
    assign done     = busy_reg && (cnt_reg == '0);
    assign product  = acc_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_reg <= '0;
            mplr_reg  <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
        end else if (start) begin
            mcand_reg <= a;
            mplr_reg  <= b;
            acc_reg   <= '0;
            cnt_reg   <= CNT_W'(WIDTH - 1);
            busy_reg  <= 1'b1;
        end else if (busy_reg) begin
            acc_reg   <= acc_next;
            mcand_reg <= mcand_reg << 1;
            mplr_reg  <= mplr_reg >> 1;
            cnt_reg   <= cnt_reg - 1'b1;
            if (cnt_reg == '0) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked integer execute unit: single-cycle add/sub/and/or/slt, iterative mul.
// Optional macro ALU_OVF_EN adds a registered signed-overflow output for add/sub.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alufunction,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
`ifdef ALU_OVF_EN
    ,
    output logic             overflow
`endif
);

    state_t           state_reg, state_next;
    logic             out_valid_reg, out_valid_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             zero_reg, zero_next;

    logic [WIDTH-1:0] sum, diff, alu_res, mul_product;
    logic             sub_ovf, accept, is_mul, mul_start, mul_done;

    assign sum  = a + b;
    assign diff = a - b;
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        alu_res = '0;
        case (alufunction)
            ALU_ADD: alu_res = sum;
            ALU_SUB: alu_res = diff;
            ALU_AND: alu_res = a & b;
            ALU_OR:  alu_res = a | b;
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
            default: alu_res = '0;
        endcase
    end

    // A held, undrained result blocks every new op, including MUL starts.
    assign in_ready  = (state_reg == ST_IDLE) && (!out_valid_reg || out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (alufunction == ALU_MUL);
    assign mul_start = accept && is_mul;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:     if (mul_start) state_next = ST_MUL_BUSY;
            ST_MUL_BUSY: if (mul_done)  state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid_next = out_valid_reg && !out_ready;
        result_next    = result_reg;
        zero_next      = zero_reg;
        if (accept && !is_mul) begin
            out_valid_next = 1'b1;
            result_next    = alu_res;
            zero_next      = (alu_res == '0);
        end else if (mul_done) begin
            out_valid_next = 1'b1;
            result_next    = mul_product;
            zero_next      = (mul_product == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= out_valid_next;
            result_reg    <= result_next;
            zero_reg      <= zero_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign zero      = zero_reg;

`ifdef ALU_OVF_EN
    logic add_ovf, ovf_sel, overflow_reg;

    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign ovf_sel = (alufunction == ALU_ADD) ? add_ovf :
                     (alufunction == ALU_SUB) ? sub_ovf : 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_reg <= 1'b0;
        end else if (accept && !is_mul) begin
            overflow_reg <= ovf_sel;
        end else if (mul_done) begin
            overflow_reg <= 1'b0;
        end
    end

    assign overflow = overflow_reg;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: vector table through a scoreboard, then hand-written
// sequences for MUL latency, backpressure and reset during a multiply.
module tb_alu_exec_unit;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alufunction;
    logic [WIDTH-1:0] a, b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
`ifdef ALU_OVF_EN
    logic             overflow;
`endif

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alufunction (alufunction),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero)
`ifdef ALU_OVF_EN
        ,
        .overflow    (overflow)
`endif
    );

    typedef struct {
        logic [31:0] r;
        logic        z;
        logic        o;
    } exp_t;

    typedef struct {
        logic [3:0]  f;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] r;
        logic        z;
        logic        o;
    } vec_t;

    exp_t sb[$];
    exp_t pend;
    vec_t vecs[16];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on output transfer.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got result %h with empty scoreboard", result);
                end else begin
                    e = sb.pop_front();
                    $display("txn out: result=%h zero=%0d (expected %h/%0d)", result, zero, e.r, e.z);
                    chk("result", result, e.r);
                    chk("zero", {31'b0, zero}, {31'b0, e.z});
`ifdef ALU_OVF_EN
                    chk("overflow", {31'b0, overflow}, {31'b0, e.o});
`endif
                end
            end
            if (in_valid && in_ready) sb.push_back(pend);
        end
    end

    task automatic issue(input logic [3:0] f, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] r, input logic z, input logic o);
        alufunction = f;
        a           = x;
        b           = y;
        pend        = '{r, z, o};
        in_valid    = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 200 cycles");
        in_valid = 1'b0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  n;
        bit  busy_ok;
        bit  stray;

        vecs[0]  = '{4'b0010, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0};
        vecs[1]  = '{4'b0110, 32'd9,          32'd9,          32'd0,          1'b1, 1'b0};
        vecs[2]  = '{4'b0111, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0};
        vecs[3]  = '{4'b0111, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0};
        vecs[4]  = '{4'b0000, 32'hF0F0_00FF,  32'h0FF0_0F0F,  32'h00F0_000F,  1'b0, 1'b0};
        vecs[5]  = '{4'b0001, 32'hF0F0_00FF,  32'h0FF0_0F0F,  32'hFFF0_0FFF,  1'b0, 1'b0};
        vecs[6]  = '{4'b0010, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0};
        vecs[7]  = '{4'b0110, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0, 1'b0};
        vecs[8]  = '{4'b0111, 32'h8000_0000,  32'h7FFF_FFFF,  32'd1,          1'b0, 1'b0};
        vecs[9]  = '{4'b0011, 32'd5,          32'd7,          32'd0,          1'b1, 1'b0};
        vecs[10] = '{4'b1111, 32'd5,          32'd7,          32'd0,          1'b1, 1'b0};
        vecs[11] = '{4'b0010, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0, 1'b1};
        vecs[12] = '{4'b0000, 32'h7FFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0};
        vecs[13] = '{4'b1000, 32'hFFFF_FFFF,  32'd3,          32'hFFFF_FFFD,  1'b0, 1'b0};
        vecs[14] = '{4'b0110, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0, 1'b1};
        vecs[15] = '{4'b1000, 32'd0,          32'd12345,      32'd0,          1'b1, 1'b0};

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        alufunction = 4'b0000;
        a           = '0;
        b           = '0;
        pend        = '{32'd0, 1'b0, 1'b0};
        repeat (3) step();
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_zero", {31'b0, zero}, 32'd0);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 16; i++) begin
            issue(vecs[i].f, vecs[i].x, vecs[i].y, vecs[i].r, vecs[i].z, vecs[i].o);
        end
        for (int i = 0; i < 100 && sb.size() != 0; i++) step();
        step();

        // MUL: 32 busy cycles with in_ready low, then the product.
        issue(4'b1000, 32'd1234, 32'd5678, 32'd7006652, 1'b0, 1'b0);
        n = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (out_valid) begin
                n = k;
                break;
            end
            if (in_ready) busy_ok = 1'b0;
        end
        chk("mul_latency", n, 32'd32);
        chk("mul_in_ready_low", {31'b0, busy_ok}, 32'd1);
        chk("mul_result", result, 32'd7006652);
        step();

        // Backpressure: held add result blocks the next op until out_ready rises.
        out_ready = 1'b0;
        issue(4'b0010, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0);
        alufunction = 4'b0110;
        a           = 32'd10;
        b           = 32'd4;
        pend        = '{32'd6, 1'b0, 1'b0};
        in_valid    = 1'b1;
        repeat (3) begin
            step();
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_result_held", result, 32'd7);
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_drain_and_fill_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_drain_and_fill_result", result, 32'd6);
        repeat (2) step();

        // Reset at MUL cycle 10 abandons the multiply.
        issue(4'b1000, 32'd1234, 32'd5678, 32'd7006652, 1'b0, 1'b0);
        repeat (9) step();
        rst_n = 1'b0;
        sb.delete();
        step();
        chk("rst_mul_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_mul_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_mul_result", result, 32'd0);
        rst_n = 1'b1;
        stray = 1'b0;
        repeat (40) begin
            step();
            if (out_valid) stray = 1'b1;
        end
        chk("rst_mul_no_stray", {31'b0, stray}, 32'd0);

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
